// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer write-side controller.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int FB_DEPTH  = 8;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;

  localparam logic [X_W:0] X_LIMIT = (X_W+1)'(FB_WIDTH);
  localparam logic [Y_W:0] Y_LIMIT = (Y_W+1)'(FB_HEIGHT);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;
  typedef enum logic {HOST, FILL_SRC} grant_t;

  // True when the coordinate lands on a visible pixel.
  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
  endfunction

endpackage

// File: rtl/fb_fill_controller.sv
// Owns the framebuffer write port, sharing it between a clipped rectangle-fill
// engine and a host single-pixel write stream.
module fb_fill_controller
  import fb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [X_W-1:0]      cmd_x0,
  input  logic [Y_W-1:0]      cmd_y0,
  input  logic [X_W-1:0]      cmd_w,
  input  logic [Y_W-1:0]      cmd_h,
  input  logic [FB_DEPTH-1:0] cmd_color,
  input  logic                host_wr_valid,
  output logic                host_wr_ready,
  input  logic [X_W-1:0]      host_wr_x,
  input  logic [Y_W-1:0]      host_wr_y,
  input  logic [FB_DEPTH-1:0] host_wr_data,
  output logic                fb_write_enable,
  output logic [X_W-1:0]      fb_write_x,
  output logic [Y_W-1:0]      fb_write_y,
  output logic [FB_DEPTH-1:0] fb_write_data,
  output logic                busy,
  output logic                done
);

  state_t                state, next_state;
  grant_t                last_grant;

  logic [X_W-1:0]        x0_q;
  logic [Y_W-1:0]        y0_q;
  logic [X_W-1:0]        w_q;
  logic [Y_W-1:0]        h_q;
  logic [FB_DEPTH-1:0]   color_q;
  logic [X_W:0]          x_end_q;
  logic [Y_W:0]          y_end_q;
  logic [X_W-1:0]        cur_x;
  logic [Y_W-1:0]        cur_y;

  logic                  wr_en_q;
  logic [X_W-1:0]        wr_x_q;
  logic [Y_W-1:0]        wr_y_q;
  logic [FB_DEPTH-1:0]   wr_data_q;

  logic [X_W:0]          sum_x, x_end_c;
  logic [Y_W:0]          sum_y, y_end_c;
  logic                  empty_rect;
  logic                  host_ready_int;
  logic                  host_grant;
  logic                  fill_grant;
  logic                  last_x, last_y;

  // Clipping: widened sums so x0+w and y0+h cannot wrap before the min().
  always_comb begin
    sum_x      = {1'b0, x0_q} + {1'b0, w_q};
    sum_y      = {1'b0, y0_q} + {1'b0, h_q};
    x_end_c    = (sum_x > X_LIMIT) ? X_LIMIT : sum_x;
    y_end_c    = (sum_y > Y_LIMIT) ? Y_LIMIT : sum_y;
    empty_rect = (w_q == '0) || (h_q == '0) || !in_bounds(x0_q, y0_q);
  end

  // The host only loses the port when it won the previous contended slot.
  always_comb begin
    host_ready_int = !((state == FILL) && (last_grant == HOST));
    host_grant     = host_wr_valid && host_ready_int;
    fill_grant     = (state == FILL) && !host_grant;
    last_x         = ({1'b0, cur_x} == (x_end_q - (X_W+1)'(1)));
    last_y         = ({1'b0, cur_y} == (y_end_q - (Y_W+1)'(1)));
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (cmd_valid) next_state = CLIP;
      CLIP: next_state = empty_rect ? DONE : FILL;
      FILL: if (fill_grant && last_x && last_y) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= FILL_SRC;
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
    end else begin
      state <= next_state;

      if (state == IDLE && cmd_valid) begin
        x0_q    <= cmd_x0;
        y0_q    <= cmd_y0;
        w_q     <= cmd_w;
        h_q     <= cmd_h;
        color_q <= cmd_color;
      end

      if (state == CLIP) begin
        x_end_q <= x_end_c;
        y_end_q <= y_end_c;
        cur_x   <= x0_q;
        cur_y   <= y0_q;
      end else if (fill_grant) begin
        if (last_x) begin
          cur_x <= x0_q;
          cur_y <= cur_y + Y_W'(1);
        end else begin
          cur_x <= cur_x + X_W'(1);
        end
      end

      // Each fill starts with the pointer cleared so contention opens with a host slot.
      if (state == CLIP) begin
        last_grant <= FILL_SRC;
      end else if (host_grant) begin
        last_grant <= HOST;
      end else if (fill_grant) begin
        last_grant <= FILL_SRC;
      end
    end
  end

  // Write port register; off-screen host writes complete their handshake but never reach it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (host_grant) begin
        if (in_bounds(host_wr_x, host_wr_y)) begin
          wr_en_q   <= 1'b1;
          wr_x_q    <= host_wr_x;
          wr_y_q    <= host_wr_y;
          wr_data_q <= host_wr_data;
        end
      end else if (fill_grant) begin
        wr_en_q   <= 1'b1;
        wr_x_q    <= cur_x;
        wr_y_q    <= cur_y;
        wr_data_q <= color_q;
      end
    end
  end

  // Every output reads zero for as long as reset is held.
  always_comb begin
    cmd_ready       = (state == IDLE) && !reset;
    busy            = (state != IDLE) && !reset;
    done            = (state == DONE) && !reset;
    host_wr_ready   = host_ready_int && !reset;
    fb_write_enable = wr_en_q && !reset;
    fb_write_x      = reset ? '0 : wr_x_q;
    fb_write_y      = reset ? '0 : wr_y_q;
    fb_write_data   = reset ? '0 : wr_data_q;
  end

endmodule
